// File: rtl/axi2_rd_arbiter.sv
// axi2_rd_arbiter: two-master round-robin AR arbiter with ID-tagged R routing onto one AXI2 slave read port
module axi2_rd_arbiter #(
   parameter int NUM_DATA_BITS_P   = 32,
   parameter int NUM_ADDR_BITS_P   = 32,
   parameter int NUM_ID_BITS_P     = 4,
   parameter int NUM_BURST_BITS_P  = 4,
   parameter int MAX_OUTSTANDING_P = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [NUM_ID_BITS_P-1:0]    s0_arid,
   input  logic [NUM_ADDR_BITS_P-1:0]  s0_araddr,
   input  logic [NUM_BURST_BITS_P-1:0] s0_arlen,
   input  logic [2:0]                  s0_arsize,
   input  logic [1:0]                  s0_arburst,
   input  logic [1:0]                  s0_arlock,
   input  logic [3:0]                  s0_arcache,
   input  logic [2:0]                  s0_arprot,
   input  logic                        s0_arvalid,
   output logic                        s0_arready,
   output logic [NUM_ID_BITS_P-1:0]    s0_rid,
   output logic [NUM_DATA_BITS_P-1:0]  s0_rdata,
   output logic [1:0]                  s0_rresp,
   output logic                        s0_rlast,
   output logic                        s0_rvalid,
   input  logic                        s0_rready,
   input  logic [NUM_ID_BITS_P-1:0]    s1_arid,
   input  logic [NUM_ADDR_BITS_P-1:0]  s1_araddr,
   input  logic [NUM_BURST_BITS_P-1:0] s1_arlen,
   input  logic [2:0]                  s1_arsize,
   input  logic [1:0]                  s1_arburst,
   input  logic [1:0]                  s1_arlock,
   input  logic [3:0]                  s1_arcache,
   input  logic [2:0]                  s1_arprot,
   input  logic                        s1_arvalid,
   output logic                        s1_arready,
   output logic [NUM_ID_BITS_P-1:0]    s1_rid,
   output logic [NUM_DATA_BITS_P-1:0]  s1_rdata,
   output logic [1:0]                  s1_rresp,
   output logic                        s1_rlast,
   output logic                        s1_rvalid,
   input  logic                        s1_rready,
   output logic [NUM_ID_BITS_P:0]      m_arid,
   output logic [NUM_ADDR_BITS_P-1:0]  m_araddr,
   output logic [NUM_BURST_BITS_P-1:0] m_arlen,
   output logic [2:0]                  m_arsize,
   output logic [1:0]                  m_arburst,
   output logic [1:0]                  m_arlock,
   output logic [3:0]                  m_arcache,
   output logic [2:0]                  m_arprot,
   output logic                        m_arvalid,
   input  logic                        m_arready,
   input  logic [NUM_ID_BITS_P:0]      m_rid,
   input  logic [NUM_DATA_BITS_P-1:0]  m_rdata,
   input  logic [1:0]                  m_rresp,
   input  logic                        m_rlast,
   input  logic                        m_rvalid,
   output logic                        m_rready
);
   localparam int CW = $clog2(MAX_OUTSTANDING_P + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING_P);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;
   logic gnt, gnt_nxt, rr, rr_nxt, busy, elig0, elig1, ar_hs, sel, r_done;
   logic [CW-1:0] cnt0, cnt1;

   function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] c, input logic inc, input logic dec);
      return (inc && !dec) ? c + CW'(1) : (dec && !inc) ? c - CW'(1) : c;
   endfunction

   assign busy  = state == BUSY;
   assign elig0 = s0_arvalid && cnt0 < MAX_C;
   assign elig1 = s1_arvalid && cnt1 < MAX_C;

   assign m_arvalid  = busy && (gnt ? s1_arvalid : s0_arvalid);
   assign m_arid     = {gnt, gnt ? s1_arid : s0_arid};
   assign m_araddr   = gnt ? s1_araddr  : s0_araddr;
   assign m_arlen    = gnt ? s1_arlen   : s0_arlen;
   assign m_arsize   = gnt ? s1_arsize  : s0_arsize;
   assign m_arburst  = gnt ? s1_arburst : s0_arburst;
   assign m_arlock   = gnt ? s1_arlock  : s0_arlock;
   assign m_arcache  = gnt ? s1_arcache : s0_arcache;
   assign m_arprot   = gnt ? s1_arprot  : s0_arprot;
   assign s0_arready = busy && !gnt && m_arready;
   assign s1_arready = busy && gnt && m_arready;
   assign ar_hs      = m_arvalid && m_arready;

   assign sel       = m_rid[NUM_ID_BITS_P];
   assign s0_rvalid = m_rvalid && !sel;
   assign s1_rvalid = m_rvalid && sel;
   assign s0_rid    = m_rid[NUM_ID_BITS_P-1:0];
   assign s1_rid    = m_rid[NUM_ID_BITS_P-1:0];
   assign s0_rdata  = m_rdata;
   assign s1_rdata  = m_rdata;
   assign s0_rresp  = m_rresp;
   assign s1_rresp  = m_rresp;
   assign s0_rlast  = m_rlast;
   assign s1_rlast  = m_rlast;
   assign m_rready  = sel ? s1_rready : s0_rready;
   assign r_done    = m_rvalid && m_rready && m_rlast;

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      rr_nxt    = rr;
      if (!busy && (elig0 || elig1)) begin
         state_nxt = BUSY;
         gnt_nxt   = (elig0 && elig1) ? rr : elig1;
      end else if (ar_hs) begin
         state_nxt = IDLE;
         rr_nxt    = !gnt;
      end
   end

   // an rlast arriving on a zero counter is a slave error and is ignored
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
         gnt   <= 1'b0;
         rr    <= 1'b0;
         cnt0  <= '0;
         cnt1  <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         rr    <= rr_nxt;
         cnt0  <= cnt_upd(cnt0, ar_hs && !gnt, r_done && !sel && cnt0 != '0);
         cnt1  <= cnt_upd(cnt1, ar_hs && gnt, r_done && sel && cnt1 != '0);
      end
   end
endmodule

// File: tb/tb_axi2_rd_arbiter.sv
// tb_axi2_rd_arbiter: directed and random stimulus against a transaction-level model of the read arbiter
module tb_axi2_rd_arbiter;
   localparam int DW = 32, AW = 32, IW = 4, BW = 4, MO = 2;

   typedef struct {int m; logic [IW-1:0] id; int len;} burst_t;

   logic aclk = 1'b0, aresetn = 1'b0;
   always #5 aclk = ~aclk;

   logic [IW-1:0] arid [2];
   logic [AW-1:0] araddr [2];
   logic [BW-1:0] arlen [2];
   logic [2:0] arsize [2], arprot [2];
   logic [1:0] arburst [2], arlock [2];
   logic [3:0] arcache [2];
   logic [1:0] arvalid, arready, rready, rvalid_o, rlast_o;
   logic [IW-1:0] rid_o [2];
   logic [DW-1:0] rdata_o [2];
   logic [1:0] rresp_o [2];
   logic [IW:0] m_arid, m_rid;
   logic [AW-1:0] m_araddr;
   logic [BW-1:0] m_arlen;
   logic [2:0] m_arsize, m_arprot;
   logic [1:0] m_arburst, m_arlock, m_rresp;
   logic [3:0] m_arcache;
   logic [DW-1:0] m_rdata;
   logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

   axi2_rd_arbiter #(.NUM_DATA_BITS_P(DW), .NUM_ADDR_BITS_P(AW), .NUM_ID_BITS_P(IW),
                     .NUM_BURST_BITS_P(BW), .MAX_OUTSTANDING_P(MO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s0_arid(arid[0]), .s0_araddr(araddr[0]), .s0_arlen(arlen[0]), .s0_arsize(arsize[0]),
      .s0_arburst(arburst[0]), .s0_arlock(arlock[0]), .s0_arcache(arcache[0]), .s0_arprot(arprot[0]),
      .s0_arvalid(arvalid[0]), .s0_arready(arready[0]), .s0_rid(rid_o[0]), .s0_rdata(rdata_o[0]),
      .s0_rresp(rresp_o[0]), .s0_rlast(rlast_o[0]), .s0_rvalid(rvalid_o[0]), .s0_rready(rready[0]),
      .s1_arid(arid[1]), .s1_araddr(araddr[1]), .s1_arlen(arlen[1]), .s1_arsize(arsize[1]),
      .s1_arburst(arburst[1]), .s1_arlock(arlock[1]), .s1_arcache(arcache[1]), .s1_arprot(arprot[1]),
      .s1_arvalid(arvalid[1]), .s1_arready(arready[1]), .s1_rid(rid_o[1]), .s1_rdata(rdata_o[1]),
      .s1_rresp(rresp_o[1]), .s1_rlast(rlast_o[1]), .s1_rvalid(rvalid_o[1]), .s1_rready(rready[1]),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready));

   int total = 0, passed = 0;
   // model: owner is the master currently presented downstream (-1 none), rr has priority
   int owner = -1, rr = 0, cnt [2] = '{0, 0};
   burst_t out_q [$];
   bit hs_seen, r_fired, busy_r;
   int hs_m, beat, lat;
   burst_t cur;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic adv();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_cycle();
      int o, sel;
      bit ev, e0, e1;
      burst_t nb;
      #3;
      if (!aresetn) begin
         owner = -1; rr = 0; cnt[0] = 0; cnt[1] = 0;
         out_q.delete();
      end
      o  = owner;
      ev = (o >= 0) ? arvalid[o] : 1'b0;
      chk("m_arvalid", m_arvalid, ev);
      if (ev) begin
         chk("m_arid", m_arid, {o[0], arid[o]});
         chk("m_araddr", m_araddr, araddr[o]);
         chk("m_arlen", m_arlen, arlen[o]);
         chk("m_arsize", m_arsize, arsize[o]);
         chk("m_arburst", m_arburst, arburst[o]);
         chk("m_arlock", m_arlock, arlock[o]);
         chk("m_arcache", m_arcache, arcache[o]);
         chk("m_arprot", m_arprot, arprot[o]);
      end
      for (int n = 0; n < 2; n++) chk("arready", arready[n], (o == n) && m_arready);
      sel = m_rid[IW];
      for (int n = 0; n < 2; n++) begin
         chk("rvalid", rvalid_o[n], m_rvalid && sel == n);
         chk("rid", rid_o[n], m_rid[IW-1:0]);
         chk("rdata", rdata_o[n], m_rdata);
         chk("rresp", rresp_o[n], m_rresp);
         chk("rlast", rlast_o[n], m_rlast);
      end
      chk("m_rready", m_rready, rready[sel]);
      hs_seen = ev && m_arready;
      hs_m    = o;
      r_fired = m_rvalid && rready[sel];
      if (aresetn) begin
         if (hs_seen) begin
            cnt[o]++;
            rr = 1 - o;
            owner = -1;
            nb.m = o; nb.id = arid[o]; nb.len = int'(arlen[o]);
            out_q.push_back(nb);
         end else if (o < 0) begin
            e0 = arvalid[0] && cnt[0] < MO;
            e1 = arvalid[1] && cnt[1] < MO;
            owner = (e0 && e1) ? rr : e1 ? 1 : e0 ? 0 : -1;
         end
         if (r_fired && m_rlast && cnt[sel] > 0) begin
            cnt[sel]--;
            for (int i = 0; i < out_q.size(); i++)
               if (out_q[i].m == sel && out_q[i].id == m_rid[IW-1:0]) begin
                  out_q.delete(i);
                  break;
               end
         end
      end
   endtask

   task automatic issue(input int n, input logic [IW-1:0] id, input logic [AW-1:0] addr, input int maxc, output int l);
      l = -1;
      arvalid[n] = 1'b1; arid[n] = id; araddr[n] = addr; arlen[n] = '0;
      arsize[n] = 3'd2; arburst[n] = 2'd1; arlock[n] = '0; arcache[n] = 4'd3; arprot[n] = 3'd1;
      for (int i = 0; i < maxc && l < 0; i++) begin
         chk_cycle();
         if (hs_seen && hs_m == n) l = i;
         adv();
      end
      if (l >= 0) arvalid[n] = 1'b0;
   endtask

   task automatic rbeat(input int n, input logic [IW-1:0] id, input bit last);
      m_rvalid = 1'b1; m_rid = {n[0], id}; m_rdata = $urandom; m_rresp = 2'd0; m_rlast = last;
      chk_cycle();
      adv();
      m_rvalid = 1'b0; m_rlast = 1'b0;
   endtask

   task automatic drain();
      burst_t b;
      rready = 2'b11;
      for (int g = 0; g < 64 && out_q.size() > 0; g++) begin
         b = out_q[0];
         for (int k = 0; k <= b.len; k++) rbeat(b.m, b.id, k == b.len);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0; arvalid = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1; busy_r = 1'b0;
      chk_cycle();
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_s0_arready", arready[0], 0);
      chk("rst_s1_arready", arready[1], 0);
      adv();
      aresetn = 1'b1;
   endtask

   initial begin
      int hsm [$], hst [$];
      for (int n = 0; n < 2; n++) begin
         arid[n] = '0; araddr[n] = '0; arlen[n] = '0; arsize[n] = '0;
         arburst[n] = '0; arlock[n] = '0; arcache[n] = '0; arprot[n] = '0;
      end
      arvalid = 2'b00; rready = 2'b11; m_arready = 1'b1;
      m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
      #1;
      do_reset();

      // single master, 4-beat burst
      arvalid[0] = 1'b1; arid[0] = 4'd3; araddr[0] = 'h100; arlen[0] = 4'd3;
      chk_cycle();
      chk("t1_idle_arvalid", m_arvalid, 0);
      adv();
      chk_cycle();
      chk("t1_arvalid", m_arvalid, 1);
      chk("t1_arid", m_arid, 5'h03);
      chk("t1_araddr", m_araddr, 'h100);
      chk("t1_arready", arready[0], 1);
      adv();
      arvalid[0] = 1'b0;
      for (int b = 0; b < 4; b++) begin
         m_rvalid = 1'b1; m_rid = 5'h03; m_rdata = 32'hA000 + b; m_rlast = (b == 3);
         chk_cycle();
         chk("t1_s0_rvalid", rvalid_o[0], 1);
         chk("t1_s1_rvalid", rvalid_o[1], 0);
         chk("t1_s0_rdata", rdata_o[0], 32'hA000 + b);
         adv();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;

      // contention from reset: grants alternate 0,1,0,1 two cycles apart
      do_reset();
      arvalid = 2'b11; arid[0] = 4'd1; arid[1] = 4'd2; arlen[0] = '0; arlen[1] = '0;
      for (int c = 0; c < 10; c++) begin
         chk_cycle();
         if (m_arvalid && m_arready) begin
            hsm.push_back(int'(m_arid[IW]));
            hst.push_back(c);
         end
         adv();
      end
      arvalid = 2'b00;
      chk("cont_count", hsm.size(), 4);
      for (int i = 0; i < 4 && i < hsm.size(); i++) begin
         chk("cont_master", hsm[i], i % 2);
         chk("cont_cycle", hst[i], 2 * i + 1);
      end
      drain();

      // outstanding limit on s1
      issue(1, 4'd5, 'h500, 6, lat); chk("lim_first", lat, 1);
      issue(1, 4'd6, 'h600, 6, lat); chk("lim_second", lat, 1);
      issue(1, 4'd7, 'h700, 6, lat); chk("lim_blocked", lat, -1);
      issue(0, 4'd9, 'h900, 6, lat); chk("lim_s0_granted", lat, 1);
      rbeat(1, 4'd5, 1'b1);
      issue(1, 4'd7, 'h700, 6, lat); chk("lim_after_rlast", lat, 1);
      drain();

      // backpressure holds the grant
      m_arready = 1'b0;
      arvalid[0] = 1'b1; arid[0] = 4'd4; araddr[0] = 'h200; arlen[0] = 4'd1;
      chk_cycle();
      adv();
      arvalid[1] = 1'b1; arid[1] = 4'd8; araddr[1] = 'h300; arlen[1] = '0;
      arsize[1] = 3'd2; arburst[1] = 2'd1; arlock[1] = '0; arcache[1] = 4'd3; arprot[1] = 3'd1;
      for (int c = 0; c < 5; c++) begin
         chk_cycle();
         chk("bp_arvalid", m_arvalid, 1);
         chk("bp_msb", m_arid[IW], 0);
         chk("bp_addr", m_araddr, 'h200);
         chk("bp_s1_arready", arready[1], 0);
         adv();
      end
      m_arready = 1'b1;
      chk_cycle();
      chk("bp_hs", arready[0], 1);
      adv();
      arvalid[0] = 1'b0;
      issue(1, 4'd8, 'h300, 6, lat); chk("bp_s1_next", lat, 1);
      drain();

      // AR handshake and rlast for s0 in the same cycle
      issue(0, 4'd2, 'h400, 6, lat); chk("sim_first", lat, 1);
      arvalid[0] = 1'b1; arid[0] = 4'd3; araddr[0] = 'h500; arlen[0] = '0;
      chk_cycle();
      adv();
      m_rvalid = 1'b1; m_rid = 5'h02; m_rlast = 1'b1;
      chk_cycle();
      chk("sim_ar_hs", arready[0], 1);
      chk("sim_r_hs", rvalid_o[0] && m_rready, 1);
      adv();
      m_rvalid = 1'b0; m_rlast = 1'b0; arvalid[0] = 1'b0;
      issue(0, 4'd4, 'h600, 6, lat); chk("sim_one_left", lat, 1);
      issue(0, 4'd5, 'h700, 6, lat); chk("sim_full", lat, -1);

      // reset while BUSY
      m_arready = 1'b0;
      rbeat(0, 4'd3, 1'b1);
      chk_cycle();
      adv();
      chk_cycle();
      chk("rb_busy_arvalid", m_arvalid, 1);
      adv();
      aresetn = 1'b0; m_arready = 1'b1;
      chk_cycle();
      chk("rb_arvalid", m_arvalid, 0);
      chk("rb_s0_arready", arready[0], 0);
      chk("rb_s1_arready", arready[1], 0);
      adv();
      aresetn = 1'b1; arvalid = 2'b00;
      chk_cycle();
      chk("rb_idle_arvalid", m_arvalid, 0);
      adv();
      issue(0, 4'd1, 'h800, 6, lat); chk("rb_cnt_a", lat, 1);
      issue(0, 4'd2, 'h810, 6, lat); chk("rb_cnt_b", lat, 1);

      // random traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         aresetn = ($urandom_range(0, 599) != 0);
         if (!aresetn) begin
            arvalid = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0; busy_r = 1'b0;
         end else begin
            for (int n = 0; n < 2; n++)
               if (!arvalid[n] || (hs_seen && hs_m == n)) begin
                  arvalid[n] = ($urandom_range(0, 2) != 0);
                  arid[n] = 4'($urandom); araddr[n] = $urandom; arlen[n] = 4'($urandom_range(0, 3));
                  arsize[n] = 3'($urandom); arburst[n] = 2'($urandom); arlock[n] = 2'($urandom);
                  arcache[n] = 4'($urandom); arprot[n] = 3'($urandom);
               end
            if (r_fired) begin
               m_rvalid = 1'b0;
               if (m_rlast) busy_r = 1'b0;
               else beat++;
            end
            if (!m_rvalid) begin
               if (!busy_r && out_q.size() > 0) begin
                  cur = out_q[$urandom_range(0, out_q.size() - 1)];
                  beat = 0;
                  busy_r = 1'b1;
               end
               if (busy_r && $urandom_range(0, 3) != 0) begin
                  m_rvalid = 1'b1; m_rid = {cur.m[0], cur.id}; m_rdata = $urandom;
                  m_rresp = 2'($urandom); m_rlast = (beat == cur.len);
               end
            end
            rready[0] = ($urandom_range(0, 3) != 0);
            rready[1] = ($urandom_range(0, 3) != 0);
            m_arready = ($urandom_range(0, 2) != 0);
         end
         chk_cycle();
         adv();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/axi2_rd_arbiter.md
# axi2_rd_arbiter

Two-master round-robin arbiter for the AXI v2.0 read path (AR and R channels). It shares one downstream AXI2 slave read port between two upstream masters. Downstream it widens ARID by one bit to tag the originating master, and it routes R beats back by that tag. It sits between the interconnect master ports and a single memory or peripheral slave.

## Interface
- NUM_DATA_BITS_P, 32, data width of RDATA on all ports
- NUM_ADDR_BITS_P, 32, address width
- NUM_ID_BITS_P, 4, upstream ID width; downstream ID width is NUM_ID_BITS_P+1
- NUM_BURST_BITS_P, 4, ARLEN width
- MAX_OUTSTANDING_P, 4, maximum accepted-but-incomplete bursts per master (≥1)
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  asynchronous active-low reset
- sN_arid, sN_araddr, sN_arlen, sN_arsize, sN_arburst, sN_arlock, sN_arcache, sN_arprot, sN_arvalid  input  ID/ADDR/BURST/3/2/2/4/3/1  AR from master N (N=0,1)
- sN_arready  output  1  AR accept to master N
- sN_rid, sN_rdata, sN_rresp, sN_rlast, sN_rvalid  output  ID/DATA/2/1/1  R to master N
- sN_rready  input  1  R accept from master N
- m_arid  output  ID+1  {granted master index, sN_arid}
- m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arvalid  output  ADDR/BURST/3/2/2/4/3/1  AR to slave
- m_arready  input  1  slave AR accept
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  input  ID+1/DATA/2/1/1  R from slave
- m_rready  output  1  R accept to slave

## Operation
- AR FSM has two states: IDLE and BUSY. Registered state: grant index gnt, round-robin pointer rr (the master with priority), and per-master outstanding counters cnt0/cnt1, each $clog2(MAX_OUTSTANDING_P+1) bits wide.
- Eligibility: eligN = sN_arvalid && cntN < MAX_OUTSTANDING_P.
- IDLE:
  - If exactly one master is eligible, it is granted.
  - If both are eligible, master rr is granted.
  - On a grant: gnt <= winner, next state BUSY.
  - With no eligible master, stay in IDLE.
- BUSY:
  - m_arvalid = s[gnt]_arvalid.
  - All m_ar* fields are a combinational mux of s[gnt]_ar*.
  - m_arid = {gnt, s[gnt]_arid}.
  - s[gnt]_arready = m_arready. The non-granted arready is 0.
  - On m_arvalid && m_arready: cnt[gnt]++, rr <= ~gnt, next state IDLE.
- The grant is never revoked in BUSY. Masters are AXI-compliant and hold arvalid until handshake.
- R routing is combinational: sel = m_rid[NUM_ID_BITS_P].
  - sN_rvalid = m_rvalid && sel==N.
  - sN_rid = m_rid[NUM_ID_BITS_P-1:0].
  - sN_rdata, sN_rresp and sN_rlast are driven from m_r* to both masters.
  - m_rready = s[sel]_rready.
- Counter update:
  - cnt[sel]-- on m_rvalid && m_rready && m_rlast.
  - When the same counter gets an increment and a decrement in one cycle, it is unchanged.
  - A counter never underflows. An rlast handshake while cnt==0 is a slave protocol error: the counter holds at 0.
- All sN_arready and the m_arvalid qualifier are 0 in IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) sets:
  - state=IDLE, gnt=0, rr=0, cnt0=cnt1=0.
  - Hence m_arvalid=0 and s0_arready=s1_arready=0.
  - sN_rvalid and m_rready follow their combinational inputs.
- AR latency: sN_arvalid high in cycle T (while in IDLE and eligible) gives m_arvalid high in cycle T+1. With m_arready=1 the handshake completes at T+1.
- AR throughput: at most one burst every 2 cycles. It returns to IDLE for one cycle after each handshake.
- R path has zero latency: combinational from m_r* to sN_r* and from sN_rready to m_rready.
- Reset mid-burst: all state clears immediately.
  - The in-flight AR is dropped and counters are zeroed.
  - The system must reset the slave simultaneously.
- An R beat for master N is independent of AR activity. AR and R handshakes may occur in the same cycle.

## Test plan
- Single master: s0 issues araddr=0x100, arid=3, arlen=3. Required: m_arvalid rises 1 cycle later with m_arid=0x03. The slave returns 4 beats with m_rid=0x03, and only s0_rvalid toggles. cnt0 goes 0→1→0 after rlast.
- Contention: s0 and s1 hold arvalid continuously with m_arready=1. Grants alternate 0,1,0,1 (m_arid MSB alternates). Each AR handshake is spaced 2 cycles apart.
- Outstanding limit: MAX_OUTSTANDING_P=2, s1 issues 3 ARs, no R returned. The third stays unaccepted (s1_arready=0) while s0 requests are still granted. After one s1 burst completes (rlast with m_rid=0x10|id), the third is accepted.
- Backpressure: m_arready=0 for 5 cycles during BUSY. The grant stays on the same master, and m_ar* are stable each cycle. There is no switch even when the other master asserts arvalid.
- Simultaneous inc/dec: AR handshake for s0 in the same cycle as s0 rlast handshake with cnt0=1. cnt0 stays 1.
- Reset during BUSY with m_arvalid=1: aresetn low. m_arvalid=0 and sN_arready=0 in the same cycle. After release, the FSM is in IDLE and both counters are 0.
